do_fb_monitor: RTL

Drives one digital-output channel's fp_channel and fd_channel lines and consumes the channel's din_feedback readback.
Checks feedback against the expected value (fp_channel OR fd_channel), debounces mismatches and latches a sticky fault code.
Runs on-demand test pulses on fd_channel to prove the readback path while the output is commanded low.
Sits between the station's DO command logic and the DO channel/feedback stage.

---
 rtl/do_fb_pkg.sv | 27 ++
 rtl/do_fb_sync.sv | 32 +++
 rtl/do_fb_monitor.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/do_fb_pkg.sv
// -----------------------------------------------------------------------------
// do_fb_pkg
// Shared types and constants for the digital-output feedback monitor.
//   fb_state_e   : monitor FSM states (settle, monitor, test pulse, test end)
//   FC_*         : sticky fault codes reported on fault_code
//   stuck_code() : maps the expected output level to the stuck-at fault code
// -----------------------------------------------------------------------------
package do_fb_pkg;

    typedef enum logic [1:0] {
        StSettle  = 2'd0,
        StMonitor = 2'd1,
        StTest    = 2'd2,
        StTestEnd = 2'd3
    } fb_state_e;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_STUCK_LO = 2'b01;
    localparam logic [1:0] FC_STUCK_HI = 2'b10;
    localparam logic [1:0] FC_TP_FAIL  = 2'b11;

    // Expected high but read low is stuck-low, and the reverse is stuck-high.
    function automatic logic [1:0] stuck_code(input logic expected);
        return expected ? FC_STUCK_LO : FC_STUCK_HI;
    endfunction

endpackage

// File: rtl/do_fb_sync.sv
// -----------------------------------------------------------------------------
// do_fb_sync
// Two-flop synchronizer for a single asynchronous input, reset to 0.
// Ports:
//   i_clk : destination clock
//   i_rst : synchronous active-high reset
//   i_d   : asynchronous input
//   o_q   : synchronized output (two clock latency)
// -----------------------------------------------------------------------------
module do_fb_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/do_fb_monitor.sv
// -----------------------------------------------------------------------------
// do_fb_monitor
// Drives one DO channel (fp_channel, fd_channel), compares the synchronized
// readback against fp_channel | fd_channel, debounces mismatches into a sticky
// fault code and runs on-demand test pulses on fd_channel while the output is
// commanded low.
// Optional build macro: DO_FB_AUTO_TEST_EN adds an internal test request every
// AUTO_PERIOD cycles, restarted after each test_done.
// Ports:
//   clk          : system clock
//   rst          : synchronous active-high reset
//   do_cmd       : commanded output level
//   test_req     : single-cycle request for a readback test pulse
//   fault_clr    : single-cycle clear of the sticky fault
//   din_feedback : asynchronous readback from the channel
//   fp_channel   : output drive
//   fd_channel   : diagnostic drive, high only during a test pulse
//   fb_fault     : sticky fault flag
//   fault_code   : 00 none, 01 stuck-low, 10 stuck-high, 11 test-pulse fail
//   test_done    : one-cycle pulse at the end of a test (or a rejected request)
//   test_ok      : test result, valid while test_done is high
// -----------------------------------------------------------------------------
module do_fb_monitor
    import do_fb_pkg::*;
#(
    parameter int unsigned SETTLE_CYC  = 8,
    parameter int unsigned DEB_CYC     = 4,
    parameter int unsigned TP_CYC      = 16,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned AUTO_PERIOD = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       do_cmd,
    input  logic       test_req,
    input  logic       fault_clr,
    input  logic       din_feedback,
    output logic       fp_channel,
    output logic       fd_channel,
    output logic       fb_fault,
    output logic [1:0] fault_code,
    output logic       test_done,
    output logic       test_ok
);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TP_LAST     = CNT_W'(TP_CYC - 1);
    localparam logic [CNT_W-1:0] DEB_MAX     = CNT_W'(DEB_CYC);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_CYC - 1);

    fb_state_e        r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic [CNT_W-1:0] r_mis, w_mis_d;
    logic             r_fp, w_fp_d;
    logic             r_fd, w_fd_d;
    logic             r_fault, w_fault_d;
    logic [1:0]       r_code, w_code_d;
    logic             r_done, w_done_d;
    logic             r_ok, w_ok_d;

    logic             w_fb_s;
    logic             w_expected;
    logic             w_det;
    logic [1:0]       w_det_code;
    logic             w_test_req;

    do_fb_sync u_fb_sync (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (din_feedback),
        .o_q   (w_fb_s)
    );

`ifdef DO_FB_AUTO_TEST_EN
    localparam int unsigned AUTO_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);

    logic [AUTO_W-1:0] r_auto_cnt;
    logic              w_auto_req;

    assign w_auto_req = (r_auto_cnt == AUTO_LAST);

    // Period restarts after every test_done so tests stay AUTO_PERIOD apart.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_auto_cnt <= '0;
        end else if (r_done || w_auto_req) begin
            r_auto_cnt <= '0;
        end else begin
            r_auto_cnt <= r_auto_cnt + AUTO_W'(1);
        end
    end

    assign w_test_req = test_req | w_auto_req;
`else
    logic w_unused_auto;
    assign w_unused_auto = (AUTO_PERIOD != 0);
    assign w_test_req    = test_req;
`endif

    assign w_expected = r_fp | r_fd;

    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_mis_d    = r_mis;
        w_fp_d     = r_fp;
        w_fd_d     = r_fd;
        // A request not accepted below is answered as rejected next cycle.
        w_done_d   = w_test_req;
        w_ok_d     = 1'b0;
        w_det      = 1'b0;
        w_det_code = FC_NONE;

        unique case (r_state)
            StSettle: begin
                w_fp_d  = do_cmd;
                w_mis_d = '0;
                if (do_cmd != r_fp) begin
                    w_cnt_d = '0;
                end else if (r_cnt == SETTLE_LAST) begin
                    w_state_d = StMonitor;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + CNT_ONE;
                end
            end

            StMonitor: begin
                if (w_test_req && !r_fp) begin
                    // Accepted test holds fp; any do_cmd change waits until SETTLE.
                    w_state_d = StTest;
                    w_fd_d    = 1'b1;
                    w_cnt_d   = '0;
                    w_done_d  = 1'b0;
                end else if (do_cmd != r_fp) begin
                    w_fp_d    = do_cmd;
                    w_state_d = StSettle;
                    w_cnt_d   = '0;
                    w_mis_d   = '0;
                end else if (w_fb_s != w_expected) begin
                    if (r_mis < DEB_MAX) begin
                        w_mis_d = r_mis + CNT_ONE;
                    end
                    if (r_mis == DEB_LAST) begin
                        w_det      = 1'b1;
                        w_det_code = stuck_code(w_expected);
                    end
                end else begin
                    w_mis_d = '0;
                end
            end

            StTest: begin
                if (r_cnt == TP_LAST) begin
                    w_fd_d    = 1'b0;
                    w_state_d = StTestEnd;
                    w_cnt_d   = '0;
                    w_done_d  = 1'b1;
                    w_ok_d    = w_fb_s;
                    if (!w_fb_s) begin
                        w_det      = 1'b1;
                        w_det_code = FC_TP_FAIL;
                    end
                end else begin
                    w_cnt_d = r_cnt + CNT_ONE;
                end
            end

            StTestEnd: begin
                // Pick up the latest command on the way back into SETTLE.
                w_fp_d    = do_cmd;
                w_state_d = StSettle;
                w_cnt_d   = '0;
            end

            default: begin
                w_state_d = StSettle;
                w_cnt_d   = '0;
            end
        endcase

        // Clearing restarts the debounce, so a persistent fault re-asserts
        // after a full DEB_CYC window rather than immediately.
        if (fault_clr && !w_det) begin
            w_mis_d = '0;
        end
    end

    // Sticky fault: first fault wins; a detection beats a simultaneous clear.
    always_comb begin
        w_fault_d = r_fault;
        w_code_d  = r_code;
        if (fault_clr) begin
            w_fault_d = 1'b0;
            w_code_d  = FC_NONE;
        end
        if (w_det && (!r_fault || fault_clr)) begin
            w_fault_d = 1'b1;
            w_code_d  = w_det_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StSettle;
            r_cnt   <= '0;
            r_mis   <= '0;
            r_fp    <= 1'b0;
            r_fd    <= 1'b0;
            r_fault <= 1'b0;
            r_code  <= FC_NONE;
            r_done  <= 1'b0;
            r_ok    <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_mis   <= w_mis_d;
            r_fp    <= w_fp_d;
            r_fd    <= w_fd_d;
            r_fault <= w_fault_d;
            r_code  <= w_code_d;
            r_done  <= w_done_d;
            r_ok    <= w_ok_d;
        end
    end

    assign fp_channel = r_fp;
    assign fd_channel = r_fd;
    assign fb_fault   = r_fault;
    assign fault_code = r_code;
    assign test_done  = r_done;
    assign test_ok    = r_ok;

endmodule
